vcr_op_credit_ctrl: RTL

Output-port credit and VC-state controller for the VC router, generalised over VC count, buffer depth and reservation policy. It tracks downstream buffer occupancy per output VC using a shared pool plus per-VC static reservations, and accepts multi-credit returns per cycle. It also runs a per-OVC allocation FSM that produces full, almost-full and eligibility masks for the VC and switch allocators. Control-only: the flit datapath lives in the channel-output stage.

---
 rtl/vcr_op_credit_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/vcr_op_credit_ctrl.sv
// vcr_op_credit_ctrl
// Output-port credit and VC-state controller for the VC router. It tracks how
// full the downstream buffer is for each output VC. The buffer is split into a
// static reservation per VC plus a shared pool that all VCs draw from. Each
// output VC also runs a small allocation FSM. This block is control only: the
// flit datapath lives in the channel-output stage.
//
// Optional build macro: VCR_OP_CREDIT_BYPASS_EN
//   defined   : a credit arriving this cycle is reflected combinationally in
//               full_ovc / almost_full_ovc. The flit sent in the same cycle is
//               not included in that view.
//   undefined : every output is registered, so credits take 1 cycle to show.
//   The register state is the same in both builds.
//
// Ports:
//   clk             clock
//   reset           asynchronous reset, active low
//   credit_valid    a credit return event is present
//   credit_vc       VC that receives the credits
//   credit_count    number of credits returned (1..max_credit_return)
//   flit_valid      a flit was sent downstream this cycle
//   flit_vc         VC of the sent flit
//   flit_head       the sent flit is a head flit
//   flit_tail       the sent flit is a tail flit
//   vc_gnt_ovc      one-hot OVC grant from the VC allocator
//   full_ovc        no slot is available to the VC
//   almost_full_ovc exactly one slot is available to the VC
//   elig_ovc        the VC is IDLE and can be allocated
//   error           sticky protocol / accounting error
//
// Allocation FSM, one per output VC:
//   state  | meaning
//   IDLE   | free, can be allocated
//   ALLOC  | granted, waiting for the head flit
//   ACTIVE | packet in flight, waiting for the tail flit

module vcr_op_credit_ctrl #(
  parameter int num_vcs           = 4,
  parameter int buffer_size       = 16,
  parameter int static_reserve    = 2,
  parameter int max_credit_return = 2,
  parameter int vc_idx_width      = (num_vcs > 1) ? $clog2(num_vcs) : 1,
  parameter int cnt_width         = $clog2(max_credit_return + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    credit_valid,
  input  logic [vc_idx_width-1:0] credit_vc,
  input  logic [cnt_width-1:0]    credit_count,
  input  logic                    flit_valid,
  input  logic [vc_idx_width-1:0] flit_vc,
  input  logic                    flit_head,
  input  logic                    flit_tail,
  input  logic [num_vcs-1:0]      vc_gnt_ovc,
  output logic [num_vcs-1:0]      full_ovc,
  output logic [num_vcs-1:0]      almost_full_ovc,
  output logic [num_vcs-1:0]      elig_ovc,
  output logic                    error
);

  localparam int shared_size = buffer_size - num_vcs * static_reserve;
  localparam int uw          = $clog2(buffer_size + 1);

  localparam logic [uw-1:0] res_c     = uw'(static_reserve);
  localparam logic [uw-1:0] shared_c  = uw'(shared_size);
  localparam logic [uw-1:0] one_c     = uw'(1);
  localparam logic [uw-1:0] avail_rst = uw'(static_reserve + shared_size);

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_alloc  = 2'd1;
  localparam logic [1:0] st_active = 2'd2;

  // Slots a VC holds beyond its reservation. These are the slots it takes
  // from the shared pool.
  function automatic logic [uw-1:0] excess(input logic [uw-1:0] u);
    return (u > res_c) ? (u - res_c) : '0;
  endfunction

  function automatic logic [uw-1:0] avail(input logic [uw-1:0] u, input logic [uw-1:0] sh);
    logic [uw-1:0] r;
    r = (u < res_c) ? (res_c - u) : '0;
    return r + (shared_c - sh);
  endfunction

  logic [num_vcs-1:0][uw-1:0] used_q, used_d;
  logic [uw-1:0]              shared_q, shared_d;
  logic [num_vcs-1:0][1:0]    state_q, state_d;
  logic [num_vcs-1:0]         full_q, full_d, af_q, af_d;
  logic [num_vcs-1:0]         fl_hit, cr_hit;
  logic                       error_q, err_evt;

  always_comb begin
    fl_hit = '0;
    cr_hit = '0;
    for (int v = 0; v < num_vcs; v++) begin
      fl_hit[v] = flit_valid   && (flit_vc   == vc_idx_width'(v));
      cr_hit[v] = credit_valid && (credit_vc == vc_idx_width'(v));
    end
  end

  always_comb begin
    logic [uw-1:0] amt;
    logic [uw-1:0] up;
    logic          take;
    amt      = '0;
    up       = '0;
    take     = 1'b0;
    used_d   = used_q;
    state_d  = state_q;
    shared_d = '0;
    full_d   = '0;
    af_d     = '0;
    err_evt  = credit_valid && (credit_count == '0);

    // A flit and a credit on the same VC collapse into one net delta.
    // Shared usage is then re-derived from the resulting counts.
    for (int v = 0; v < num_vcs; v++) begin
      amt  = cr_hit[v] ? uw'(credit_count) : '0;
      take = fl_hit[v] && (avail(used_q[v], shared_q) != '0);
      if (fl_hit[v] && !take) err_evt = 1'b1;
      up = used_q[v] + {{(uw-1){1'b0}}, take};
      if (amt > up) begin
        err_evt   = 1'b1;
        used_d[v] = '0;
      end else begin
        used_d[v] = up - amt;
      end
    end

    for (int v = 0; v < num_vcs; v++) shared_d = shared_d + excess(used_d[v]);

    for (int v = 0; v < num_vcs; v++) begin
      full_d[v] = (avail(used_d[v], shared_d) == '0);
      af_d[v]   = (avail(used_d[v], shared_d) == one_c);
    end

    for (int v = 0; v < num_vcs; v++) begin
      case (state_q[v])
        st_idle: begin
          if (fl_hit[v]) err_evt = 1'b1;
          if (vc_gnt_ovc[v]) state_d[v] = st_alloc;
        end
        st_alloc: begin
          if (vc_gnt_ovc[v]) err_evt = 1'b1;
          if (fl_hit[v]) begin
            if (!flit_head) err_evt = 1'b1;
            else            state_d[v] = flit_tail ? st_idle : st_active;
          end
        end
        st_active: begin
          if (vc_gnt_ovc[v]) err_evt = 1'b1;
          if (fl_hit[v]) begin
            if (flit_head)      err_evt = 1'b1;
            else if (flit_tail) state_d[v] = st_idle;
          end
        end
        default: begin
          err_evt    = 1'b1;
          state_d[v] = st_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      used_q   <= '0;
      shared_q <= '0;
      state_q  <= {num_vcs{st_idle}};
      full_q   <= {num_vcs{avail_rst == '0}};
      af_q     <= {num_vcs{avail_rst == one_c}};
      error_q  <= 1'b0;
    end else begin
      used_q   <= used_d;
      shared_q <= shared_d;
      state_q  <= state_d;
      full_q   <= full_d;
      af_q     <= af_d;
      error_q  <= error_q | err_evt;
    end
  end

  always_comb begin
    elig_ovc = '0;
    for (int v = 0; v < num_vcs; v++) elig_ovc[v] = (state_q[v] == st_idle);
  end

  assign error = error_q;

`ifdef VCR_OP_CREDIT_BYPASS_EN
  // Post-credit view built from the current registered counts. A flit sent in
  // the same cycle is deliberately left out.
  logic [num_vcs-1:0][uw-1:0] used_pc;
  logic [uw-1:0]              shared_pc;
  logic [uw-1:0]              amt_pc;

  always_comb begin
    used_pc         = used_q;
    shared_pc       = '0;
    amt_pc          = '0;
    full_ovc        = full_q;
    almost_full_ovc = af_q;
    for (int v = 0; v < num_vcs; v++) begin
      amt_pc     = cr_hit[v] ? uw'(credit_count) : '0;
      used_pc[v] = (amt_pc > used_q[v]) ? '0 : (used_q[v] - amt_pc);
    end
    for (int v = 0; v < num_vcs; v++) shared_pc = shared_pc + excess(used_pc[v]);
    if (credit_valid) begin
      for (int v = 0; v < num_vcs; v++) begin
        full_ovc[v]        = (avail(used_pc[v], shared_pc) == '0);
        almost_full_ovc[v] = (avail(used_pc[v], shared_pc) == one_c);
      end
    end
  end
`else
  assign full_ovc        = full_q;
  assign almost_full_ovc = af_q;
`endif

endmodule
